// File: rtl/snoop_result_agent.sv
// snoop_result_agent
//
// Clocked model of the snoop responses returned by the other caches on the
// LLC bus. A request carries a line address. SNOOP_LATENCY cycles after the
// request is accepted, the agent presents one aggregated result and one
// result per simulated cache. It holds them until the consumer takes them.
//
// Result encoding: HIT = 2'b00, HITM = 2'b01, NOHIT = 2'b10 (2'b11 unused).
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    snoop request present
//   req_ready    agent can accept a request (only in IDLE, low during reset)
//   req_addr     snooped address
//   rsp_valid    response present (driven from state only)
//   rsp_ready    consumer accepts the response
//   rsp_result   aggregated result (any HITM > any HIT > NOHIT)
//   rsp_vector   per-cache results; cache c in bits [2c+1:2c]
//   rsp_addr     address of the request being answered
//   hit_cnt, hitm_cnt, nohit_cnt
//                saturating counters of aggregated results, one step per
//                response handshake. These exist only when the macro
//                SNOOP_STATS_EN is defined.
//
// Configuration macro: SNOOP_STATS_EN (statistics counters).

module snoop_result_agent #(
  parameter int ADDRESS_SIZE  = 32,
  parameter int NUM_CACHES    = 1,
  parameter int SNOOP_LATENCY = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_SIZE-1:0]   req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_result,
  output logic [2*NUM_CACHES-1:0]   rsp_vector,
  output logic [ADDRESS_SIZE-1:0]   rsp_addr
`ifdef SNOOP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      hit_cnt,
  output logic [CNT_WIDTH-1:0]      hitm_cnt,
  output logic [CNT_WIDTH-1:0]      nohit_cnt
`endif
);

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b10;

  // A 4-bit counter covers the full 1..15 latency range.
  localparam logic [3:0] LAT_LOAD = 4'(SNOOP_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                lat_q, lat_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic [2*NUM_CACHES-1:0]   vec_q, vec_d;
  logic [1:0]                res_q, res_d;

  logic                      req_fire;
  logic                      rsp_fire;

  // Per-cache lookup from the captured address. Cache c sees the low address
  // bits rotated by c, so cache 0 keeps the legacy single-cache mapping.
  logic [2*NUM_CACHES-1:0]   cache_res;
  logic [NUM_CACHES-1:0]     cache_hit;
  logic [NUM_CACHES-1:0]     cache_hitm;
  logic [1:0]                agg_res;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CACHES; gi++) begin : g_cache
      logic [1:0] k;
      assign k                   = addr_q[1:0] + 2'(gi);
      assign cache_hit[gi]       = (k == 2'd0);
      assign cache_hitm[gi]      = (k == 2'd1);
      assign cache_res[2*gi +: 2] = (k == 2'd0) ? RES_HIT  :
                                   (k == 2'd1) ? RES_HITM : RES_NOHIT;
    end
  endgenerate

  assign agg_res = (|cache_hitm) ? RES_HITM :
                   (|cache_hit)  ? RES_HIT  : RES_NOHIT;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      vec_q   <= {NUM_CACHES{RES_NOHIT}};
      res_q   <= RES_NOHIT;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    vec_d   = vec_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          addr_d  = req_addr;
          lat_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == 4'd0) begin
          vec_d   = cache_res;
          res_d   = agg_res;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. The state stays IDLE while reset is held, so req_ready is
  // gated with rst_n to keep it low until reset is released.
  always_comb begin
    req_ready  = rst_n && (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
    rsp_result = res_q;
    rsp_vector = vec_q;
    rsp_addr   = addr_q;
  end

`ifdef SNOOP_STATS_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] hitm_cnt_q, hitm_cnt_d;
  logic [CNT_WIDTH-1:0] nohit_cnt_q, nohit_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      hitm_cnt_q  <= '0;
      nohit_cnt_q <= '0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      hitm_cnt_q  <= hitm_cnt_d;
      nohit_cnt_q <= nohit_cnt_d;
    end
  end

  // Count the delivered result once per handshake; saturate at all-ones.
  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    hitm_cnt_d  = hitm_cnt_q;
    nohit_cnt_d = nohit_cnt_q;
    if (rsp_fire) begin
      if (res_q == RES_HIT && hit_cnt_q != '1) begin
        hit_cnt_d = hit_cnt_q + 1'b1;
      end
      if (res_q == RES_HITM && hitm_cnt_q != '1) begin
        hitm_cnt_d = hitm_cnt_q + 1'b1;
      end
      if (res_q == RES_NOHIT && nohit_cnt_q != '1) begin
        nohit_cnt_d = nohit_cnt_q + 1'b1;
      end
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign hitm_cnt  = hitm_cnt_q;
  assign nohit_cnt = nohit_cnt_q;
`endif

endmodule
